// File: rtl/line_buf_3x3_pkg.sv
// Shared pixel/window sizing for the 3x3 line buffer
// and the Gaussian filter that consumes its windows.
package line_buf_3x3_pkg;
  localparam int DSIZE = 8;
  localparam int WIN_W = DSIZE * 9;
endpackage

// File: rtl/line_buf_3x3_delay.sv
// Fixed-depth pixel delay line, advanced only when en_i is high.
// Output is the sample written DEPTH enabled cycles earlier.
module line_delay
  import line_buf_3x3_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 640
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;

  // Read-before-write at the same slot gives a DEPTH-sample delay
  assign q_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q + 1'b1;
    if (ptr_q == AW'(DEPTH - 1)) ptr_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   ptr_q <= '0;
    else if (en_i) ptr_q <= ptr_d;
  end

  always_ff @(posedge clk_i) begin
    if (en_i) mem_q[ptr_q] <= d_i;
  end
endmodule

// File: rtl/line_buf_3x3.sv
// Raster-stream 3x3 window generator: two line delays plus
// a shifting 3x3 register array, border windows suppressed.
module line_buf_3x3
  import line_buf_3x3_pkg::*;
#(
  parameter int DSIZE = line_buf_3x3_pkg::DSIZE,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [DSIZE-1:0]   i_pixel,
  output logic               o_valid,
  output logic [DSIZE*9-1:0] o_window
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0]    x_q, x_d, cx;
  logic [YW-1:0]    y_q, y_d, cy;
  logic             vld_q, vld_d;
  logic [DSIZE-1:0] l1, l2;
  logic [DSIZE-1:0] win_q [3][3];

  line_delay #(.DW(DSIZE), .DEPTH(IMG_W)) u_l1 (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   (i_valid),
    .d_i    (i_pixel),
    .q_o    (l1)
  );

  line_delay #(.DW(DSIZE), .DEPTH(IMG_W)) u_l2 (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   (i_valid),
    .d_i    (l1),
    .q_o    (l2)
  );

  // i_sof overrides the tracked position of the current pixel
  always_comb begin
    cx    = i_sof ? '0 : x_q;
    cy    = i_sof ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    vld_d = 1'b0;
    if (i_valid) begin
      vld_d = (cx >= XW'(2)) && (cy >= YW'(2));
      if (cx == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (cy == YW'(IMG_H - 1)) ? '0 : cy + 1'b1;
      end else begin
        x_d = cx + 1'b1;
        y_d = cy;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
      win_q <= '{default: '0};
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      vld_q <= vld_d;
      if (i_valid) begin
        win_q[0]    <= win_q[1];
        win_q[1]    <= win_q[2];
        win_q[2][0] <= l2;
        win_q[2][1] <= l1;
        win_q[2][2] <= i_pixel;
      end
    end
  end

  // Index k = 3*col + row, index 0 in the top slice
  always_comb begin
    o_window = '0;
    for (int k = 0; k < 9; k++) begin
      o_window[DSIZE*9-1-k*DSIZE -: DSIZE] = win_q[k/3][k%3];
    end
  end

  assign o_valid = vld_q;
endmodule

// File: doc/line_buf_3x3.md
LINE_BUF_3X3 -- requirements
Module: line_buf_3x3

Interface
REQ-001 Parameter DSIZE, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 640, pixels per line (minimum 3).
REQ-003 Parameter IMG_H, default 480, lines per frame (minimum 3).
REQ-004 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port i_valid  input  1  i_pixel carries a raster-order pixel this cycle.
REQ-007 Port i_sof  input  1  with i_valid, marks the pixel as position (x=0, y=0); ignored without i_valid.
REQ-008 Port i_pixel  input  DSIZE  incoming pixel.
REQ-009 Port o_valid  output  1  o_window holds a complete 3x3 neighbourhood this cycle.
REQ-010 Port o_window  output  DSIZE*9  packed 3x3 window in the filter input format.

Function
REQ-011 The block SHALL track input position with counters x (0..IMG_W-1) and y (0..IMG_H-1), advanced only on cycles with i_valid=1.
REQ-012 On i_valid: x=IMG_W-1 wraps x to 0 and increments y; x=IMG_W-1 with y=IMG_H-1 wraps both to 0; i_sof=1 forces the accepted pixel to (0,0), with the next pixel at (1,0).
REQ-013 The block SHALL keep two line delays of IMG_W pixels each: L1 returns the pixel at (x, y-1) and L2 the pixel at (x, y-2), both aligned with the accepted pixel.
REQ-014 A 3x3 register array SHALL shift one column per accepted pixel; the new column is {L2 out, L1 out, i_pixel} as rows {0,1,2}, and the oldest column is discarded.
REQ-015 Window index k SHALL map to column k/3 (0 = oldest, x-2) and row k%3 (0 = line y-2); index 8 is the newest pixel (x, y).
REQ-016 Packing: index k SHALL occupy o_window[DSIZE*9-1-k*DSIZE -: DSIZE], so index 0 is in the most significant byte.
REQ-017 o_valid SHALL be registered and asserted exactly one cycle after accepting a pixel with x>=2 and y>=2; the window is centred on (x-1, y-1).
REQ-018 Border windows SHALL NOT be emitted: each frame produces (IMG_W-2)*(IMG_H-2) valid outputs; windows spanning a line wrap are suppressed.
REQ-019 With i_valid=0: no counters, line delays or window registers change; o_valid is 0 on the next cycle; o_window holds its last value.
REQ-020 The block SHALL have no back-pressure: every i_valid pixel is consumed, and the downstream consumer accepts one window per cycle.
REQ-021 Arbitrary i_valid gaps SHALL NOT change the sequence of emitted windows.

Reset
REQ-022 While i_rst_n=0: x=0, y=0, o_valid=0, o_window=0, and all window registers are 0.
REQ-023 Line delay contents need no reset; stale data SHALL never reach o_valid=1 because of REQ-017.
REQ-024 A reset mid-frame SHALL treat the first pixel after reset as (0,0).

Structure
REQ-025 DSIZE and the window width DSIZE*9 SHALL be defined in a shared package used by this block and the Gaussian filter.
REQ-026 Each line delay SHALL be an instance of one sub-module, line_delay: an IMG_W-deep, DSIZE-wide delay with an enable, two instances chained (L2 input = L1 output).

Verification (bench parameters: IMG_W=4, IMG_H=4, DSIZE=8)
REQ-027 Ramp pixel = 4*y+x, continuous i_valid, i_sof on the first pixel -> first o_valid one cycle after pixel 10, with o_window = 0x00_04_08_01_05_09_02_06_0A; exactly 4 windows per frame.
REQ-028 Same ramp with i_valid low on every other cycle -> identical window sequence and count; o_valid is never high on two consecutive cycles.
REQ-029 Two back-to-back frames, with i_sof only on the first pixel of frame 1 -> frame 2 yields the same 4 windows; the first is at pixel 10 of frame 2.
REQ-030 i_rst_n pulsed low after pixel 6, then the ramp restarts -> o_valid=0 during reset; the first window appears after the 11th post-reset pixel, with the value from REQ-027.
REQ-031 i_sof asserted at position (1,2) -> counters resync to (0,0); no window emitted until x>=2 and y>=2 of the new frame.
REQ-032 Constant 255 input chained into the Gaussian filter -> every filter output = 255 (filter internal sums are 255, 510, 255; 1020>>2 = 255).
